// File: rtl/gray_code_counter.sv
// Up/down counter with registered Gray output, binary mirror, terminal count and wrap pulse.
// Latency: zero added; a step at edge N is visible after N. No backpressure; steps only when en.
// Build option GRAY_CNT_SAT_EN: saturate at the terminal count instead of wrapping (wrap tied 0).
module gray_code_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] next_b;
   logic [WIDTH-1:0] load_bin;
   logic             next_wrap;

   // Each binary bit is the parity of the Gray bits at and above it.
   always_comb begin
      load_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         load_bin[i] = ^(load_gray >> i);
      end
   end

   assign tc = up ? (&b) : ~(|b);

   always_comb begin
      next_b    = b;
      next_wrap = 1'b0;
      if (clr) begin
         next_b = '0;
      end else if (load) begin
         next_b = load_bin;
      end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
         if (!tc) begin
            next_b = up ? (b + WIDTH'(1)) : (b - WIDTH'(1));
         end
`else
         next_b    = up ? (b + WIDTH'(1)) : (b - WIDTH'(1));
         next_wrap = tc;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b        <= '0;
         gray_out <= '0;
         wrap     <= 1'b0;
      end else begin
         b        <= next_b;
         gray_out <= next_b ^ (next_b >> 1);
         wrap     <= next_wrap;
      end
   end

   assign bin_out = b;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter (WIDTH=4); expectations follow GRAY_CNT_SAT_EN if defined.
module tb_gray_code_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       load;
   logic [3:0] load_gray;
   logic       en;
   logic       up;
   logic [3:0] gray_out;
   logic [3:0] bin_out;
   logic       tc;
   logic       wrap;

   int checks   = 0;
   int failures = 0;

   logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                             4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000};
   logic [3:0] prev;

   gray_code_counter #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
      .en(en), .up(up), .gray_out(gray_out), .bin_out(bin_out), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_gray = 4'h0; en = 1'b0; up = 1'b0;
      #12;
      check("rst_gray", gray_out, 0);
      check("rst_bin", bin_out, 0);
      check("rst_wrap", wrap, 0);
      check("rst_tc_down", tc, 1);
      up = 1'b1;
      #1;
      check("rst_tc_up", tc, 0);

      // Count up through the full sequence
      step();
      rst_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         prev = gray_out;
         step();
         check($sformatf("up_gray_%0d", i + 1), gray_out, gtab[i + 1]);
         check($sformatf("up_bin_%0d", i + 1), bin_out, i + 1);
         check($sformatf("up_onebit_%0d", i + 1), $countones(gray_out ^ prev), 1);
         check($sformatf("up_wrap_%0d", i + 1), wrap, 0);
      end
      check("up_tc_at_15", tc, 1);

      // Up wrap
      prev = gray_out;
      step();
`ifdef GRAY_CNT_SAT_EN
      check("upwrap_gray", gray_out, 4'b1000);
      check("upwrap_bin", bin_out, 15);
      check("upwrap_wrap", wrap, 0);
`else
      check("upwrap_gray", gray_out, 4'b0000);
      check("upwrap_bin", bin_out, 0);
      check("upwrap_wrap", wrap, 1);
      check("upwrap_onebit", $countones(gray_out ^ prev), 1);
`endif
      en = 1'b0;
      step();
      check("upwrap_pulse_end", wrap, 0);

      // Down wrap from zero
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_bin", bin_out, 0);
      up = 1'b0; en = 1'b1;
      #1;
      check("down_tc_at_0", tc, 1);
      prev = gray_out;
      step();
`ifdef GRAY_CNT_SAT_EN
      check("dnwrap_gray", gray_out, 4'b0000);
      check("dnwrap_bin", bin_out, 0);
      check("dnwrap_wrap", wrap, 0);
`else
      check("dnwrap_gray", gray_out, 4'b1000);
      check("dnwrap_bin", bin_out, 15);
      check("dnwrap_wrap", wrap, 1);
      check("dnwrap_onebit", $countones(gray_out ^ prev), 1);
      check("dnwrap_tc_at_15", tc, 0);
`endif
      en = 1'b0;
      step();
      check("dnwrap_pulse_end", wrap, 0);

      // Load priority over en, clr priority over load
      load = 1'b1; load_gray = 4'b1101; en = 1'b1; up = 1'b1;
      step();
      check("load_bin", bin_out, 9);
      check("load_gray", gray_out, 4'b1101);
      check("load_wrap", wrap, 0);
      clr = 1'b1;
      step();
      check("clr_over_load_gray", gray_out, 0);
      check("clr_over_load_bin", bin_out, 0);
      clr = 1'b0; load_gray = 4'b1000;
      step();
      check("load15_bin", bin_out, 15);
      check("load15_tc", tc, 1);
      load = 1'b0; en = 1'b0;

      // Async reset mid-count
      clr = 1'b1;
      step();
      clr = 1'b0; en = 1'b1; up = 1'b1;
      repeat (6) step();
      check("pre_rst_bin", bin_out, 6);
      check("pre_rst_gray", gray_out, 4'b0101);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_gray", gray_out, 0);
      check("async_rst_bin", bin_out, 0);
      step();
      check("rst_hold_bin", bin_out, 0);
      rst_n = 1'b1;
      step();
      check("post_rst_gray", gray_out, 4'b0001);
      check("post_rst_bin", bin_out, 1);

      // Direction toggle around 5
      load = 1'b1; load_gray = 4'b0111;
      step();
      load = 1'b0;
      check("toggle_start_bin", bin_out, 5);
      for (int k = 0; k < 4; k++) begin
         up = (k % 2 == 0);
         step();
         check($sformatf("toggle_bin_%0d", k), bin_out, (k % 2 == 0) ? 6 : 5);
         check($sformatf("toggle_gray_%0d", k), gray_out, (k % 2 == 0) ? 4'b0101 : 4'b0111);
         check($sformatf("toggle_wrap_%0d", k), wrap, 0);
      end

      // Hold with en low
      en = 1'b0; up = 1'b1;
      step();
      check("hold_bin", bin_out, 5);
      check("hold_tc", tc, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Up/down counter whose primary output is a registered Gray code. It is the stage directly upstream of the gray_to_binary decoder.
- Produces the 4-bit (default) Gray sequence 0000, 0001, 0011, 0010, ..., 1000 and wraps.
- Also provides a registered binary mirror, a terminal-count flag and a wrap pulse, so downstream decode and pointer logic can be checked directly.
- Accepts a Gray-coded load value and decodes it internally.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear to zero
- load  input  1  synchronous load of load_gray
- load_gray  input  WIDTH  Gray-coded load value
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- gray_out  output  WIDTH  registered Gray count
- bin_out  output  WIDTH  registered binary equivalent of gray_out
- tc  output  1  terminal count (combinational from registers and up)
- wrap  output  1  one-cycle pulse, registered, after a wrapping step

Behaviour:
- Reset: rst_n low asynchronously forces bin_out=0, gray_out=0, wrap=0. State is held while rst_n is low. Release is synchronous to the next clk edge. No step occurs on the edge where rst_n is low.
- State: binary register b.
  - gray_out is registered as next_b ^ (next_b >> 1), so gray_out and bin_out update on the same edge.
  - Zero cycles of added latency: the step decided at edge N is visible after edge N.
- Per-edge priority: clr > load > en.
  - clr=1: b <= 0; wrap <= 0.
  - else load=1: b <= Gray-to-binary of load_gray (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]); wrap <= 0. en is ignored.
  - else en=1 and up=1: b <= b+1 modulo 2^WIDTH.
  - else en=1 and up=0: b <= b-1 modulo 2^WIDTH.
  - else: hold; wrap <= 0.
- tc:
  - up=1: tc=1 when b = 2^WIDTH-1.
  - up=0: tc=1 when b = 0.
  - Evaluated on current registers and the live up input.
- wrap: set to 1 for exactly one cycle after an enabled step taken while tc=1 (up: all-ones -> 0; down: 0 -> all-ones). Otherwise 0.
- Single-bit rule: every en-driven step changes exactly one bit of gray_out, including both wrap transitions. clr and load may change any number of bits.
- Direction change mid-sequence is allowed every cycle. The step uses the up value sampled at that edge.
- bin_out always equals the Gray decode of gray_out. The decoder downstream must reproduce bin_out exactly.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN.
- Defined:
  - An enabled step while tc=1 holds the count unchanged.
  - wrap is tied to 0.
  - tc is still reported.
  - The count saturates at all-ones (up) or zero (down).
- Undefined: modulo wrap-around as described above.

Test Plan:
- Reset and count up: rst_n=0 then release; en=1, up=1 for 16 cycles -> gray_out follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000; bin_out follows 0..15; exactly one bit changes per step.
- Up wrap: from gray 1000 (bin 15), tc=1, step with en=1 -> gray 0000 and wrap=1 for one cycle. Under GRAY_CNT_SAT_EN: stays at 1000 and wrap=0.
- Down wrap: from 0, up=0, en=1 -> gray 1000, bin 15, wrap pulse. Under GRAY_CNT_SAT_EN: stays at 0.
- Load priority: load=1, load_gray=1101, en=1 -> bin_out=9, gray_out=1101. Same cycle with clr=1 also asserted -> 0000.
- Async reset mid-count: assert rst_n low between clock edges at bin=6 -> outputs 0 immediately, without waiting for clk. After release, the first enabled up step -> gray 0001.
- Direction toggle: at bin=5, alternate up=1/0 with en=1 each cycle -> bin_out toggles 6, 5, 6, 5; gray_out toggles 0101/0111; wrap stays 0.
